debug_unit: RTL
===============

// Module: debug_unit
// PURPOSE
//  Byte-command controller between the UART (rx/tx byte ports) and the mips core.
//  Loads programs into instruction memory and runs or single-steps the pipeline.
//  Streams PC, cycle count, register bank and low data memory back to the host.
//  Replaces the simulation-only register and memory probes with a hardware path.
// PARAMETERS
//  IMEM_DEPTH  256  instruction memory words; load address wraps modulo this
//  NUM_REGS    32   registers dumped, indices 0..NUM_REGS-1
//  DUMP_WORDS  32   data memory words dumped, word addresses 0..DUMP_WORDS-1
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low
//  rx_data       in   8   received byte
//  rx_valid      in   1   one-cycle strobe: rx_data valid
//  tx_data       out  8   byte to transmit
//  tx_start      out  1   one-cycle strobe: send tx_data
//  tx_busy       in   1   UART transmitter busy
//  i_halt        in   1   HALT reached WB; level, sticky until o_cpu_reset
//  i_pc          in   32  current IF PC
//  o_cpu_enable  out  1   pipeline advances on cycles where this is 1
//  o_cpu_reset   out  1   synchronous reset to core (PC=0, pipeline regs cleared)
//  o_imem_we     out  1   instruction memory write enable
//  o_imem_addr   out  8   instruction memory word address
//  o_imem_wdata  out  32  instruction word
//  o_reg_addr    out  5   register bank debug read address
//  i_reg_data    in   32  register read data, valid 1 cycle after o_reg_addr
//  o_mem_addr    out  8   data memory debug word address
//  i_mem_data    in   32  data memory read data, valid 1 cycle after o_mem_addr
// BEHAVIOUR
//  Reset: all outputs 0, including tx_data and addresses; state IDLE; cycle counter 0.
//  Commands, accepted only in IDLE; any other byte is ignored:
//    'L' 0x4C: load program.
//    'R' 0x52: run until halt, then dump.
//    'S' 0x53: step one cycle, then dump.
//    'D' 0x44: dump only.
//  rx_valid strobes arriving outside IDLE/LOAD_CNT/LOAD_BYTE are dropped.
//  LOAD:
//    - LOAD_CNT takes the next byte N = word count.
//    - LOAD_BYTE takes 4*N bytes, MSB first.
//    - Each 4th byte triggers LOAD_WRITE: o_imem_we=1 for one cycle, addr = word index
//      (wraps modulo IMEM_DEPTH).
//    - o_cpu_reset is held 1 from the 'L' byte until the ack has been sent.
//    - The cycle counter is cleared when the ack is sent.
//    - Ack is the single byte 0x4B 'K'. N=0 sends 'K' with no writes.
//  RUN:
//    - o_cpu_enable is registered and goes 1 the cycle after 'R'.
//    - The cycle after i_halt is sampled 1, enable is 0 and the FSM enters DUMP.
//    - If i_halt is already 1 when 'R' arrives, enable stays 0 and the FSM dumps directly.
//  STEP: o_cpu_enable=1 for exactly one cycle (0 if i_halt=1), then DUMP.
//  Cycle counter: 32-bit, +1 on every cycle with o_cpu_enable=1; wraps at 2^32.
//  DUMP stream, every word MSB first (8+4*NUM_REGS+4*DUMP_WORDS bytes; 264 default):
//    1. PC, latched on DUMP entry.
//    2. Cycle count, latched on DUMP entry.
//    3. R0..R(NUM_REGS-1).
//    4. MEM[0..DUMP_WORDS-1].
//  Fetch sequencing: DUMP_FETCH drives the address; DUMP_LATCH captures the data
//    1 cycle later; DUMP_SEND emits 4 bytes; then the next word.
//  TX handshake:
//    - tx_start is asserted only in a cycle where tx_busy=0, and tx_data is stable that cycle.
//    - tx_busy is ignored in the cycle after tx_start.
//    - The next byte waits for tx_busy=0.
//  FSM states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, LOAD_ACK, RUN, STEP, DUMP_FETCH,
//    DUMP_LATCH, DUMP_SEND, DUMP_WAIT.
//    After the last dump byte the FSM returns to IDLE.
//  Simultaneous events: i_halt rising in the same cycle as 'R' acceptance is treated as
//    halted (no enable pulse).
//  reset asserted mid-operation (load, run or dump): immediate abort; all outputs 0;
//    partial imem contents are left as is.
// TESTING
//  1. After reset, 'L',N=2,00000000,FFFFFFFF:
//     - exactly two imem writes: addr0=0x00000000, addr1=0xFFFFFFFF.
//     - tx sends 'K'.
//     - o_cpu_reset falls after the ack.
//  2. 'S' with i_pc=0x4, regs Rk=k, MEM[k]=0x100+k:
//     - o_cpu_enable high exactly 1 cycle.
//     - 264 bytes: 00000004, 00000001, 00000000..0000001F, 00000100..0000011F.
//  3. 'R' with core asserting i_halt after 20 enable cycles:
//     - enable low the cycle after i_halt.
//     - dumped cycle count = 20.
//     - a second 'R' dumps immediately with count still 20.
//  4. tx_busy held 1 for 50 cycles per byte:
//     - no tx_start while busy.
//     - no byte lost or duplicated across the full dump.
//  5. Unrelated bytes 0x00, 0x41 in IDLE: ignored. 'D' sent during a dump: dropped.
//     Byte count is still 264.
//  6. reset pulled low after 3 load bytes: all outputs 0. Then 'L',N=0: only 'K' sent.

Source files
------------

// File: rtl/debug_unit.sv
// Byte-command debug controller between a UART byte interface and the pipelined core:
// program load, run-to-halt, single step, and a PC/cycle/register/memory dump stream.
module debug_unit #(
  parameter int IMEM_DEPTH = 256,
  parameter int NUM_REGS   = 32,
  parameter int DUMP_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        i_halt,
  input  logic [31:0] i_pc,
  output logic        o_cpu_enable,
  output logic        o_cpu_reset,
  output logic        o_imem_we,
  output logic [7:0]  o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic [4:0]  o_reg_addr,
  input  logic [31:0] i_reg_data,
  output logic [7:0]  o_mem_addr,
  input  logic [31:0] i_mem_data
);

  localparam int          IMEM_AW  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [7:0]  NREG8    = 8'(NUM_REGS);
  localparam logic [7:0]  LAST_IDX = 8'(2 + NUM_REGS + DUMP_WORDS - 1);
  localparam logic [7:0]  CMD_L    = 8'h4C;
  localparam logic [7:0]  CMD_R    = 8'h52;
  localparam logic [7:0]  CMD_S    = 8'h53;
  localparam logic [7:0]  CMD_D    = 8'h44;
  localparam logic [7:0]  ACK_K    = 8'h4B;

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, LOAD_ACK, RUN, STEP,
    DUMP_FETCH, DUMP_LATCH, DUMP_SEND, DUMP_WAIT
  } state_t;

  state_t               state_reg, state_next;
  logic [7:0]           words_left_reg;
  logic [IMEM_AW-1:0]   word_idx_reg;
  logic [1:0]           byte_cnt_reg;
  logic [31:0]          load_word_reg;
  logic [31:0]          shift_reg;
  logic [7:0]           tx_data_reg;
  logic                 enable_reg;
  logic [31:0]          cycle_reg;
  logic [31:0]          pc_lat_reg;
  logic [31:0]          cyc_lat_reg;
  logic [7:0]           dump_idx_reg;
  logic [7:0]           dump_off;
  logic [31:0]          dump_word;

  assign dump_off     = dump_idx_reg - 8'd2;
  assign tx_data      = tx_data_reg;
  assign o_cpu_enable = enable_reg;
  assign o_imem_addr  = 8'(word_idx_reg);
  assign o_imem_wdata = load_word_reg;

  // Dump word order: PC, cycle count, register bank, then low data memory.
  always_comb begin
    dump_word = i_mem_data;
    if (dump_idx_reg == 8'd0)      dump_word = pc_lat_reg;
    else if (dump_idx_reg == 8'd1) dump_word = cyc_lat_reg;
    else if (dump_off < NREG8)     dump_word = i_reg_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (rx_valid) begin
        case (rx_data)
          CMD_L:   state_next = LOAD_CNT;
          CMD_R:   state_next = i_halt ? DUMP_FETCH : RUN;
          CMD_S:   state_next = STEP;
          CMD_D:   state_next = DUMP_FETCH;
          default: state_next = IDLE;
        endcase
      end
      LOAD_CNT:   if (rx_valid) state_next = (rx_data == 8'd0) ? LOAD_ACK : LOAD_BYTE;
      LOAD_BYTE:  if (rx_valid && byte_cnt_reg == 2'd3) state_next = LOAD_WRITE;
      LOAD_WRITE: state_next = (words_left_reg == 8'd1) ? LOAD_ACK : LOAD_BYTE;
      LOAD_ACK:   if (!tx_busy) state_next = IDLE;
      RUN:        if (i_halt) state_next = DUMP_FETCH;
      STEP:       state_next = DUMP_FETCH;
      DUMP_FETCH: state_next = DUMP_LATCH;
      DUMP_LATCH: state_next = DUMP_SEND;
      DUMP_SEND:  if (!tx_busy) state_next = DUMP_WAIT;
      DUMP_WAIT: begin
        if (byte_cnt_reg != 2'd0)          state_next = DUMP_SEND;
        else if (dump_idx_reg == LAST_IDX) state_next = IDLE;
        else                               state_next = DUMP_FETCH;
      end
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_start    = (state_reg == LOAD_ACK || state_reg == DUMP_SEND) && !tx_busy;
    o_imem_we   = (state_reg == LOAD_WRITE);
    o_cpu_reset = (state_reg == LOAD_CNT) || (state_reg == LOAD_BYTE) ||
                  (state_reg == LOAD_WRITE) || (state_reg == LOAD_ACK);
    o_reg_addr  = '0;
    o_mem_addr  = '0;
    if ((state_reg == DUMP_FETCH || state_reg == DUMP_LATCH) && dump_idx_reg >= 8'd2) begin
      if (dump_off < NREG8) o_reg_addr = dump_off[4:0];
      else                  o_mem_addr = dump_off - NREG8;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_left_reg <= '0;
      word_idx_reg   <= '0;
      byte_cnt_reg   <= '0;
      load_word_reg  <= '0;
      shift_reg      <= '0;
      tx_data_reg    <= '0;
      enable_reg     <= 1'b0;
      cycle_reg      <= '0;
      pc_lat_reg     <= '0;
      cyc_lat_reg    <= '0;
      dump_idx_reg   <= '0;
    end else begin
      // Enable is decided from the upcoming state so a halt seen in RUN stops it next cycle.
      enable_reg <= (state_next == RUN) || (state_next == STEP && !i_halt);
      if (state_reg == LOAD_ACK && tx_start) cycle_reg <= '0;
      else if (enable_reg)                   cycle_reg <= cycle_reg + 32'd1;

      case (state_reg)
        IDLE: dump_idx_reg <= '0;
        LOAD_CNT: if (rx_valid) begin
          words_left_reg <= rx_data;
          word_idx_reg   <= '0;
          byte_cnt_reg   <= '0;
          if (rx_data == 8'd0) tx_data_reg <= ACK_K;
        end
        LOAD_BYTE: if (rx_valid) begin
          load_word_reg <= {load_word_reg[23:0], rx_data};
          byte_cnt_reg  <= byte_cnt_reg + 2'd1;
        end
        LOAD_WRITE: begin
          word_idx_reg   <= word_idx_reg + 1'b1;
          words_left_reg <= words_left_reg - 8'd1;
          if (words_left_reg == 8'd1) tx_data_reg <= ACK_K;
        end
        DUMP_FETCH: if (dump_idx_reg == 8'd0) begin
          pc_lat_reg  <= i_pc;
          cyc_lat_reg <= cycle_reg;
        end
        DUMP_LATCH: begin
          tx_data_reg  <= dump_word[31:24];
          shift_reg    <= {dump_word[23:0], 8'h00};
          byte_cnt_reg <= '0;
        end
        DUMP_SEND: if (!tx_busy) begin
          tx_data_reg  <= shift_reg[31:24];
          shift_reg    <= {shift_reg[23:0], 8'h00};
          byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
        DUMP_WAIT: if (byte_cnt_reg == 2'd0 && dump_idx_reg != LAST_IDX)
          dump_idx_reg <= dump_idx_reg + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
